// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared operation and FSM encodings for the hash/overflow key-value blocks
package hash_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/overflow_kv_store.sv
// rtl/overflow_kv_store.sv - linear-scan overflow key/value table, one entry compared per cycle
module overflow_kv_store
  import hash_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int VALUE_SIZE = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 operation,
  input  logic [WIDTH-1:0]           key,
  input  logic [VALUE_SIZE-1:0]      value_in,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [VALUE_SIZE-1:0]      value_out,
  output logic                       hit,
  output logic                       success,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  state_e                state;
  op_e                   op_q;
  logic [WIDTH-1:0]      key_q;
  logic [VALUE_SIZE-1:0] val_q;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         free_idx;
  logic                  free_found;

  logic [DEPTH-1:0]      valid;
  logic [WIDTH-1:0]      keys [DEPTH];
  logic [VALUE_SIZE-1:0] vals [DEPTH];

  logic          match;
  logic          last;
  logic          slot_avail;
  logic [IW-1:0] slot;

  // The entry under inspection in the final cycle may itself be the first free slot.
  always_comb begin
    match      = valid[idx] && (keys[idx] == key_q);
    last       = (idx == IW'(DEPTH-1));
    slot_avail = free_found || !valid[idx];
    slot       = free_found ? free_idx : idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      success    <= 1'b0;
      value_out  <= '0;
      valid      <= '0;
      count      <= '0;
      full       <= 1'b0;
      idx        <= '0;
      free_idx   <= '0;
      free_found <= 1'b0;
      op_q       <= OP_LOOKUP;
      key_q      <= '0;
      val_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= op_e'(operation);
            key_q      <= key;
            val_q      <= value_in;
            idx        <= '0;
            free_found <= 1'b0;
            req_ready  <= 1'b0;
            if (op_e'(operation) == OP_RSVD) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              hit        <= 1'b0;
              success    <= 1'b0;
              value_out  <= '0;
            end else begin
              state <= SEARCH;
            end
          end
        end

        SEARCH: begin
          if (match) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            hit        <= 1'b1;
            success    <= 1'b1;
            value_out  <= '0;
            case (op_q)
              OP_LOOKUP: value_out <= vals[idx];
              OP_INSERT: vals[idx] <= val_q;
              OP_DELETE: begin
                valid[idx] <= 1'b0;
                count      <= count - CW'(1);
                full       <= 1'b0;
              end
              default: ;
            endcase
          end else if (last) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            hit        <= 1'b0;
            value_out  <= '0;
            if (op_q == OP_INSERT && slot_avail) begin
              keys[slot]  <= key_q;
              vals[slot]  <= val_q;
              valid[slot] <= 1'b1;
              count       <= count + CW'(1);
              full        <= (count == CW'(DEPTH-1));
              success     <= 1'b1;
            end else begin
              success <= 1'b0;
            end
          end else begin
            if (!valid[idx] && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
            idx <= idx + IW'(1);
          end
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/overflow_kv_store.md
OVERFLOW_KV_STORE -- requirements
Module: overflow_kv_store

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, key width in bits.
REQ-002 The block SHALL have parameter VALUE_SIZE, default 32, value width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, number of overflow entries, integer >= 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req_valid, input, 1 bit: request present.
REQ-007 Port req_ready, output, 1 bit: the block can accept a request.
REQ-008 Port operation, input, 2 bits: 00 lookup, 01 insert, 10 delete, 11 reserved.
REQ-009 Port key, input, WIDTH bits: request key.
REQ-010 Port value_in, input, VALUE_SIZE bits: insert value.
REQ-011 Port resp_valid, output, 1 bit: response present.
REQ-012 Port resp_ready, input, 1 bit: requester accepts the response.
REQ-013 Port value_out, output, VALUE_SIZE bits: lookup result.
REQ-014 Port hit, output, 1 bit: the key was found.
REQ-015 Port success, output, 1 bit: the operation completed.
REQ-016 Port count, output, $clog2(DEPTH+1) bits: number of valid entries.
REQ-017 Port full, output, 1 bit: count == DEPTH.

Function
REQ-018 The FSM SHALL have the states IDLE, SEARCH and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, a request with req_valid=1 SHALL be accepted at the edge; the block SHALL latch operation, key and value_in, and set idx=0.
- For operations 00, 01 and 10 the FSM SHALL go to SEARCH.
- For operation 11 the FSM SHALL go to RESP with hit=0, success=0, value_out=0.
REQ-020 In SEARCH, the block SHALL compare one entry per cycle: entry idx, valid bit and key equality.
- It SHALL record the lowest invalid index seen as the free slot.
REQ-021 Lookup match at entry k: the block SHALL register hit=1, success=1 and value_out=value[k], then go to RESP.
REQ-022 Insert match at entry k: the block SHALL overwrite value[k], register hit=1 and success=1, and leave count unchanged.
REQ-023 Delete match at entry k: the block SHALL clear valid[k], register hit=1 and success=1, and decrement count.
REQ-024 Search end (idx == DEPTH-1 with no match) SHALL give these results:
- Lookup: hit=0, success=0, value_out=0.
- Delete: hit=0, success=0.
- Insert with a free slot: write key and value to the lowest free index, set its valid bit, increment count; hit=0, success=1.
- Insert with no free slot: no state change; hit=0, success=0.
REQ-025 Latency from the acceptance edge to resp_valid=1:
- A match at entry k SHALL take k+1 cycles.
- A miss SHALL take DEPTH cycles.
- Operation 11 SHALL take 1 cycle.
REQ-026 In RESP, resp_valid=1 and value_out, hit and success SHALL hold stable until resp_ready=1.
- At that edge the FSM SHALL return to IDLE.
- resp_ready=1 in the first RESP cycle gives a single-cycle response.
REQ-027 Keys SHALL be unique in the table; at most one entry matches, guaranteed by the update-on-match rule.
REQ-028 Request inputs SHALL be ignored outside IDLE, and req_valid SHALL NOT be required to hold after acceptance.
REQ-029 count and full SHALL be registered and SHALL reflect the table after the updating edge.

Reset
REQ-030 On reset=1 at an edge, the block SHALL set the FSM to IDLE and clear all valid bits.
- Outputs SHALL go to: count=0, full=0, resp_valid=0, hit=0, success=0, value_out=0, req_ready=1 in the next cycle.
REQ-031 Reset SHALL take priority in any state.
- An in-flight operation SHALL be abandoned with no write and no response.
REQ-032 Key and value storage SHALL NOT require reset.

Structure
REQ-033 Operation encodings (OP_LOOKUP, OP_INSERT, OP_DELETE, OP_RSVD) and the FSM state encoding SHALL live in a shared package, hash_pkg, used with the hash table.
REQ-034 The block SHALL be a single module with no sub-modules; storage SHALL be register arrays.

Verification
REQ-035 The bench SHALL use DEPTH=4 and cover these directed scenarios:
- Insert key 0xA value 0x11 -> resp after 4 cycles; hit=0, success=1, count=1. Then lookup 0xA -> resp after 1 cycle; hit=1, success=1, value_out=0x11.
- Insert keys 1, 2, 3, 4 -> success=1 each, full=1. Insert 5 -> success=0, count=4. Insert 2 with value 0x77 -> hit=1, success=1; a lookup of 2 returns 0x77.
- Delete 2 at entry 1 -> success=1, count=3. Insert 9 -> stored at entry 1; a lookup of 9 responds after 2 cycles.
- Delete or lookup a missing key 0xFF -> hit=0, success=0 after 4 cycles, count unchanged.
- Operation 11 -> resp after 1 cycle with success=0. Hold resp_ready=0 for 3 cycles -> outputs stable and req_ready=0 throughout.
- Assert reset mid-SEARCH during an insert -> IDLE next cycle, count=0, no resp_valid; a subsequent lookup misses.
